// File: rtl/costas_pkg.sv
// Shared types, default widths and helpers for the Costas carrier loop filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package costas_pkg;

  // Discriminator/filter sequencer states, one cycle each.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISC = 2'd1,
    FILT = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int          SUM_W_DEF   = 14;
  localparam int          FREQ_W_DEF  = 32;
  localparam logic [31:0] NCO_NOM_DEF = 32'h1E00_0000;

  // Clamp a sign-extended value into [lo, hi]; callers size-cast the result
  // back down to the width of their own destination.
  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// I/Q dump input and NCO frequency-word output bundle for the loop filter.
// Latency: n/a (wires only).
// Backpressure: none; dumps that arrive while the filter is busy are dropped.
interface costas_loop_filter_if
  import costas_pkg::*;
#(
  parameter int SUM_W  = SUM_W_DEF,
  parameter int FREQ_W = FREQ_W_DEF
);
  logic                     sum_valid;
  logic signed [SUM_W-1:0]  i_sum;
  logic signed [SUM_W-1:0]  q_sum;
  logic        [FREQ_W-1:0] freq_word;
  logic                     freq_valid;

  // Accumulator side: produces dumps, consumes the frequency word.
  modport master (
    output sum_valid, i_sum, q_sum,
    input  freq_word, freq_valid
  );

  // Loop filter side.
  modport slave (
    input  sum_valid, i_sum, q_sum,
    output freq_word, freq_valid
  );
endinterface

// File: rtl/costas_lock_detect.sv
// Carrier lock detector: counts consecutive dumps with |I| > 2|Q| while closed loop.
// Latency: lock updates on the same edge that publishes the frequency word.
// Backpressure: none; evaluated once per accepted dump via upd_i.
module costas_lock_detect #(
  parameter int SUM_W    = 14,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_i,
  input  logic                    loop_en_i,
  input  logic signed [SUM_W-1:0] i_i,
  input  logic signed [SUM_W-1:0] q_i,
  output logic                    lock_o
);
  localparam int MAG_W = SUM_W + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic signed [MAG_W-1:0] mag_i, mag_q;
  logic                    qual;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    lock_q;

  // Magnitudes are widened so |most-negative| and 2|q| both fit.
  always_comb begin
    mag_i = MAG_W'(i_i);
    mag_q = MAG_W'(q_i);
    if (i_i < 0) mag_i = -mag_i;
    if (q_i < 0) mag_q = -mag_q;
    qual  = (mag_i > (mag_q <<< 1)) && loop_en_i;
    cnt_d = cnt_q;
    if (upd_i) begin
      if (!qual)                cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // Saturating run counter; lock follows it so it drops on the first miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= (cnt_d == CNT_MAX);
    end
  end

  assign lock_o = lock_q;
endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop filter: err = sign(I)*Q through a PI filter into an NCO frequency word.
// Latency: sum_valid in cycle N gives freq_valid in N+3; one dump per 4 cycles.
// Backpressure: none; dumps arriving while busy are dropped and set sticky overrun.
// Optional lock detector enabled by defining COSTAS_LOCK_DET_EN.
module costas_loop_filter
  import costas_pkg::*;
#(
  parameter int                SUM_W    = SUM_W_DEF,
  parameter int                FREQ_W   = FREQ_W_DEF,
  parameter int                INT_W    = 32,
  parameter int                KP_SHIFT = 6,
  parameter int                KI_SHIFT = 2,
  parameter longint            INT_LIM  = 64'sd268435456,
  parameter logic [FREQ_W-1:0] NCO_NOM  = FREQ_W'(NCO_NOM_DEF),
  parameter int                LOCK_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 loop_en,
  costas_loop_filter_if.slave  bus,
  output logic                 overrun,
  output logic                 busy,
  output logic                 lock
);
  localparam int ERR_W  = SUM_W + 1;
  localparam int ISUM_W = INT_W + 1;
  localparam int ACC_W  = FREQ_W + 2;
  localparam logic signed [ACC_W-1:0] NOM_ACC  = ACC_W'(NCO_NOM);
  localparam longint                  FREQ_MAX = (64'sd1 <<< FREQ_W) - 64'sd1;

  state_e                   state_q;
  logic                     i_neg_q;
  logic signed [SUM_W-1:0]  q_q;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic signed [INT_W-1:0]  integ_q, integ_d;
  logic signed [ISUM_W-1:0] integ_sum;
  logic signed [ACC_W-1:0]  acc;
  logic        [FREQ_W-1:0] freq_word_q, freq_d;
  logic                     freq_valid_q;
  logic                     overrun_q;
  logic                     busy_q;
`ifdef COSTAS_LOCK_DET_EN
  logic signed [SUM_W-1:0]  i_q;
`endif

  // Phase discriminator: one extra bit so negating the most-negative Q is exact.
  always_comb begin
    err_d = ERR_W'(q_q);
    if (i_neg_q) err_d = -ERR_W'(q_q);
  end

  // PI filter; loop_en is sampled here so a change mid-dump applies from FILT.
  always_comb begin
    integ_sum = ISUM_W'(integ_q) + (ISUM_W'(err_q) <<< KI_SHIFT);
    integ_d   = '0;
    acc       = NOM_ACC;
    if (loop_en) begin
      integ_d = INT_W'(sat_signed(64'(integ_sum), -INT_LIM, INT_LIM));
      acc     = NOM_ACC + (ACC_W'(err_q) <<< KP_SHIFT) + ACC_W'(integ_d);
    end
    freq_d = FREQ_W'(sat_signed(64'(acc), 64'sd0, FREQ_MAX));
  end

  // Sequencer IDLE->DISC->FILT->OUT; the word, pulse and integrator are
  // registered leaving FILT so they are all visible during the OUT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      i_neg_q      <= 1'b0;
      q_q          <= '0;
      err_q        <= '0;
      integ_q      <= '0;
      freq_word_q  <= NCO_NOM;
      freq_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef COSTAS_LOCK_DET_EN
      i_q          <= '0;
`endif
    end else begin
      freq_valid_q <= 1'b0;
      if (bus.sum_valid && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.sum_valid) begin
            i_neg_q <= bus.i_sum[SUM_W-1];
            q_q     <= bus.q_sum;
`ifdef COSTAS_LOCK_DET_EN
            i_q     <= bus.i_sum;
`endif
            busy_q  <= 1'b1;
            state_q <= DISC;
          end
        end
        DISC: begin
          err_q   <= err_d;
          state_q <= FILT;
        end
        FILT: begin
          integ_q      <= integ_d;
          freq_word_q  <= freq_d;
          freq_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef COSTAS_LOCK_DET_EN
  costas_lock_detect #(
    .SUM_W    (SUM_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock (
    .clk       (clk),
    .rst       (rst),
    .upd_i     (state_q == FILT),
    .loop_en_i (loop_en),
    .i_i       (i_q),
    .q_i       (q_q),
    .lock_o    (lock)
  );
`else
  logic unused_lock_cnt;
  assign unused_lock_cnt = (LOCK_CNT != 0);
  assign lock = 1'b0;
`endif

  assign bus.freq_word  = freq_word_q;
  assign bus.freq_valid = freq_valid_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;
endmodule

// File: doc/costas_loop_filter.md
Name: costas_loop_filter

Overview:
- Downstream consumer of the per-period I and Q sums produced by the Costas-loop accumulators.
- On each dump strobe it computes a decision-directed phase error, err = sign(I)·Q.
- It runs the error through a second-order proportional-integral loop filter.
- It emits a registered carrier-NCO frequency control word with a one-cycle valid pulse.
- It sits between the I/Q summation stages and the carrier NCO, and closes the carrier-tracking loop.

Parameters:
- SUM_W, 14, width of i_sum and q_sum (two's complement).
- FREQ_W, 32, width of the NCO frequency word.
- INT_W, 32, integrator width (signed).
- KP_SHIFT, 6, proportional gain expressed as a left shift of err.
- KI_SHIFT, 2, integral gain expressed as a left shift of err.
- INT_LIM, 2**28, integrator magnitude clamp (symmetric ±INT_LIM).
- NCO_NOM, 32'h1E00_0000, nominal (zero-Doppler) frequency word.
- LOCK_CNT, 8, number of consecutive qualifying dumps required to assert lock (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- loop_en  in  1  1 = closed loop; 0 = integrator held at 0 and output forced to NCO_NOM.
- sum_valid  in  1  single-cycle strobe; i_sum and q_sum are valid this cycle.
- i_sum  in  SUM_W  signed in-phase accumulation.
- q_sum  in  SUM_W  signed quadrature accumulation.
- freq_word  out  FREQ_W  NCO frequency control word (unsigned).
- freq_valid  out  1  single-cycle pulse when freq_word updates.
- overrun  out  1  sticky; set when sum_valid arrives while busy.
- busy  out  1  high in any state other than IDLE.
- lock  out  1  carrier lock indicator (LOCK_DET_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; integrator = 0.
  - freq_word = NCO_NOM; freq_valid = 0, overrun = 0, busy = 0, lock = 0.
- FSM: IDLE → DISC → FILT → OUT → IDLE. Each state lasts one cycle.
  - IDLE: on sum_valid, capture i_sum and q_sum into registers and go to DISC.
  - DISC: err (SUM_W+1 bits, signed) = q when i ≥ 0, else −q. The width extension means negating the most-negative q cannot overflow.
  - FILT:
    - If loop_en=1: integ_next = clamp(integ + (err <<< KI_SHIFT), ±INT_LIM).
    - Then acc = NCO_NOM + (err <<< KP_SHIFT) + integ_next. The sum is evaluated in FREQ_W+2 signed bits.
    - If loop_en=0: integ_next = 0 and acc = NCO_NOM.
  - OUT: freq_word = saturate(acc, 0 .. 2^FREQ_W−1); freq_valid = 1 for this cycle; integ = integ_next.
- Latency: sum_valid in cycle N produces freq_valid in cycle N+3. Maximum throughput is one dump per 4 cycles.
- sum_valid while busy:
  - The sample is dropped and overrun is set (sticky until rst).
  - sum_valid in the OUT cycle also counts as busy.
- Simultaneous events:
  - A loop_en change mid-computation takes effect from the FILT cycle onward.
  - A loop_en change does not abort the FSM.
- Integrator clamp:
  - Saturates at exactly +INT_LIM and −INT_LIM.
  - Stays at the limit until err changes sign.
- freq_word holds its last value between updates.
- Reset mid-operation: abandons the computation, no freq_valid pulse, all state returns to reset values.

Optional Feature:
- Macro: COSTAS_LOCK_DET_EN.
- When defined:
  - In OUT, a dump qualifies when |i| > 2·|q| (magnitudes in SUM_W+2 bits).
  - A saturating counter increments on qualifying dumps and clears to 0 otherwise.
  - lock = 1 once the counter reaches LOCK_CNT; it drops on the next non-qualifying dump.
  - Dumps taken with loop_en=0 clear the counter.
- When undefined: lock is tied 0 and no counter logic is present.

Decomposition:
- Package costas_pkg holds:
  - the FSM state enum (IDLE, DISC, FILT, OUT);
  - the localparam defaults for SUM_W, FREQ_W and NCO_NOM;
  - a sat_signed function (width-generic clamp, implemented per use site).
- One sub-module is natural: costas_lock_detect (abs, compare, counter), instantiated only under COSTAS_LOCK_DET_EN.

Test Plan:
- Reset release with no strobes → freq_word = 32'h1E00_0000, freq_valid = 0, lock = 0.
- loop_en=1; i=100, q=10 at cycle N → err=10 and freq_valid at N+3.
  - integ = 40.
  - freq_word = 0x1E000000 + 640 + 40 = 0x1E0002A8.
- loop_en=1; i=−100, q=10 → err=−10 and freq_word = 0x1E000000 − 680.
  - Repeat i=−8192, q=−8192 → err=+8192 with no overflow.
- Apply 40000 dumps with i=1, q=8191 → integrator stops at 268435456 and freq_word ≤ NCO_NOM + 2^28 + 8191·64.
  - Then apply i=−1 → the integrator decreases on the next dump.
- Second sum_valid at N+1 and at N+3 → both dropped, overrun=1, single freq_valid; overrun cleared only by rst.
- COSTAS_LOCK_DET_EN defined: 8 dumps i=1000, q=100 → lock=1 after the 8th dump.
  - The next dump i=100, q=100 → lock=0.
  - rst asserted at DISC → no freq_valid pulse, all outputs at reset values.
